// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and the modulo next-value helper for the TFF counter sequencer.
package tff_count_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Out-of-range counts map to the wrap target so a corrupted bank recovers in one step.
   function automatic logic [31:0] nxt_val(input logic [31:0] q,
                                           input logic        up,
                                           input logic [31:0] modulus);
      logic [31:0] res;
      if (up) begin
         res = (q >= modulus - 32'd1) ? 32'd0 : q + 32'd1;
      end else begin
         res = ((q == 32'd0) || (q >= modulus)) ? modulus - 32'd1 : q - 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/tff_count_ctrl_tick_prescaler.sv
// Divides the run time into count steps: tick is a registered one-cycle pulse every PRESCALE enabled cycles.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic clear,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count_q, count_d;
   logic          tick_q, tick_d;

   // A disabled prescaler holds its count so counting resumes where it stopped.
   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      if (restart) begin
         count_d = '0;
      end else if (en) begin
         if (count_q == LAST) begin
            count_d = '0;
            tick_d  = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of WIDTH toggle flip-flops forming a modulo-MODULUS up/down counter.
// Optional pause input enabled by defining TFF_COUNT_CTRL_PAUSE_EN.
//
//   state | meaning
//   IDLE  | stopped, bank value held
//   CLR   | one cycle of bank clear, one_shot latched
//   RUN   | stepping the bank every PRESCALE cycles
//   DONE  | one-shot run finished at the wrap value
module tff_count_ctrl
   import tff_count_ctrl_pkg::*;
#(
   parameter int WIDTH    = 2,
   parameter int MODULUS  = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             up,
   input  logic             one_shot,
`ifdef TFF_COUNT_CTRL_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] t_out,
   output logic             tff_clear,
   output logic             busy,
   output logic             tc_pulse,
   output logic             done
);

   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

   state_t           state_q, state_d;
   logic             one_shot_q, one_shot_d;
   logic             tff_clear_q, tff_clear_d;
   logic             tc_pulse_q, tc_pulse_d;
   logic             step_q;
   logic [WIDTH-1:0] nxt_q;
   logic             wrap;
   logic             presc_restart;
   logic             presc_en;

   assign nxt_q = WIDTH'(nxt_val(32'(q_fb), up, 32'(MODULUS)));
   assign wrap  = step_q & (nxt_q == (up ? '0 : TOP_VAL));
   assign t_out = step_q ? (q_fb ^ nxt_q) : '0;

   always_comb begin
      state_d    = state_q;
      one_shot_d = one_shot_q;
      case (state_q)
         ST_IDLE: if (!stop && start) state_d = ST_CLR;
         ST_CLR:  state_d = stop ? ST_IDLE : ST_RUN;
         ST_RUN: begin
            if (stop)                    state_d = ST_IDLE;
            else if (wrap && one_shot_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (stop)       state_d = ST_IDLE;
            else if (start) state_d = ST_CLR;
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_d == ST_CLR) && (state_q != ST_CLR)) one_shot_d = one_shot;
      tff_clear_d = (state_d == ST_CLR);
      tc_pulse_d  = wrap;
   end

   // Any cycle that does not both start and stay in RUN rezeroes the prescaler.
   assign presc_restart = (state_q != ST_RUN) || (state_d != ST_RUN);
`ifdef TFF_COUNT_CTRL_PAUSE_EN
   assign presc_en = !presc_restart && !pause;
`else
   assign presc_en = !presc_restart;
`endif

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .clear   (clear),
      .en      (presc_en),
      .restart (presc_restart),
      .tick    (step_q)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= ST_IDLE;
         one_shot_q  <= 1'b0;
         tff_clear_q <= 1'b1;
         tc_pulse_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         one_shot_q  <= one_shot_d;
         tff_clear_q <= tff_clear_d;
         tc_pulse_q  <= tc_pulse_d;
      end
   end

   assign tff_clear = tff_clear_q;
   assign tc_pulse  = tc_pulse_q;
   assign busy      = (state_q == ST_CLR) || (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench: three sequencer configurations, each driving its own TFF bank model.
module tb_tff_count_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clear;
   logic       start_s [3];
   logic       stop_s  [3];
   logic       up_s    [3];
   logic       os_s    [3];
   logic [1:0] bq      [3];
   logic [1:0] t_o     [3];
   logic       tclr_o  [3];
   logic       bsy_o   [3];
   logic       tc_o    [3];
   logic       dn_o    [3];
   logic       ld;
   logic [1:0] ld_val;
`ifdef TFF_COUNT_CTRL_PAUSE_EN
   logic       pause_s = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string tag;
      int    inst;
      int    q, t, tc, bsy, dn, clr;
   } exp_t;
   exp_t sb[$];

   tff_count_ctrl #(.WIDTH(2), .MODULUS(4), .PRESCALE(1)) u_a (
      .clk(clk), .clear(clear), .start(start_s[0]), .stop(stop_s[0]), .up(up_s[0]),
      .one_shot(os_s[0]),
`ifdef TFF_COUNT_CTRL_PAUSE_EN
      .pause(pause_s),
`endif
      .q_fb(bq[0]), .t_out(t_o[0]), .tff_clear(tclr_o[0]), .busy(bsy_o[0]),
      .tc_pulse(tc_o[0]), .done(dn_o[0]));

   tff_count_ctrl #(.WIDTH(2), .MODULUS(3), .PRESCALE(1)) u_b (
      .clk(clk), .clear(clear), .start(start_s[1]), .stop(stop_s[1]), .up(up_s[1]),
      .one_shot(os_s[1]),
`ifdef TFF_COUNT_CTRL_PAUSE_EN
      .pause(pause_s),
`endif
      .q_fb(bq[1]), .t_out(t_o[1]), .tff_clear(tclr_o[1]), .busy(bsy_o[1]),
      .tc_pulse(tc_o[1]), .done(dn_o[1]));

   tff_count_ctrl #(.WIDTH(2), .MODULUS(4), .PRESCALE(3)) u_c (
      .clk(clk), .clear(clear), .start(start_s[2]), .stop(stop_s[2]), .up(up_s[2]),
      .one_shot(os_s[2]),
`ifdef TFF_COUNT_CTRL_PAUSE_EN
      .pause(pause_s),
`endif
      .q_fb(bq[2]), .t_out(t_o[2]), .tff_clear(tclr_o[2]), .busy(bsy_o[2]),
      .tc_pulse(tc_o[2]), .done(dn_o[2]));

   // TFF bank models; bank 1 can be loaded to inject an illegal value.
   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (g == 1 && ld)   bq[g] <= ld_val;
         else if (tclr_o[g]) bq[g] <= 2'b00;
         else                bq[g] <= bq[g] ^ t_o[g];
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Push the expectation for the coming edge, then pop and compare after it.
   task automatic cyc(input string tag, input int inst, input int q, input int t,
                      input int tc, input int bsy, input int dn, input int clr);
      exp_t e;
      sb.push_back('{tag, inst, q, t, tc, bsy, dn, clr});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.q   >= 0) check_val({e.tag, ".q"},         int'(bq[e.inst]),     e.q);
      if (e.t   >= 0) check_val({e.tag, ".t_out"},     int'(t_o[e.inst]),    e.t);
      if (e.tc  >= 0) check_val({e.tag, ".tc_pulse"},  int'(tc_o[e.inst]),   e.tc);
      if (e.bsy >= 0) check_val({e.tag, ".busy"},      int'(bsy_o[e.inst]),  e.bsy);
      if (e.dn  >= 0) check_val({e.tag, ".done"},      int'(dn_o[e.inst]),   e.dn);
      if (e.clr >= 0) check_val({e.tag, ".tff_clear"}, int'(tclr_o[e.inst]), e.clr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int qa[6], ta[6], tca[6];
      int qb[5], tb[5], tcb[5];
      int q1[4], t1[4];

      clear = 1'b1;
      ld = 1'b0;
      ld_val = 2'b00;
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0; stop_s[i] = 1'b0; up_s[i] = 1'b1; os_s[i] = 1'b0;
      end
      up_s[1] = 1'b0;

      // reset held 3 cycles, then release
      cyc("rst0", 0, -1, 0, 0, 0, 0, 1);
      cyc("rst1", 0, -1, 0, 0, 0, 0, 1);
      cyc("rst2", 0,  0, 0, 0, 0, 0, 1);
      clear = 1'b0;
      cyc("rel", 0, 0, 0, 0, 0, 0, 0);

      // modulo-4 up count, PRESCALE=1
      qa  = '{0, 1, 2, 3, 0, 1};
      ta  = '{1, 3, 1, 3, 1, 3};
      tca = '{0, 0, 0, 0, 1, 0};
      start_s[0] = 1'b1;
      cyc("up.clr", 0, 0, 0, 0, 1, 0, 1);
      start_s[0] = 1'b0;
      cyc("up.run0", 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cyc($sformatf("up.s%0d", i), 0, qa[i], ta[i], tca[i], 1, 0, 0);
      stop_s[0] = 1'b1;
      cyc("up.stop", 0, 2, 0, 0, 0, 0, 0);
      stop_s[0] = 1'b0;

      // modulo-3 down count with illegal-value recovery
      qb  = '{0, 2, 1, 0, 2};
      tb  = '{2, 3, 1, 2, 3};
      tcb = '{0, 1, 0, 0, 1};
      start_s[1] = 1'b1;
      cyc("dn.clr", 1, 0, 0, 0, 1, 0, 1);
      start_s[1] = 1'b0;
      cyc("dn.run0", 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc($sformatf("dn.s%0d", i), 1, qb[i], tb[i], tcb[i], 1, 0, 0);
      ld = 1'b1; ld_val = 2'd3;
      cyc("dn.ill", 1, 3, 1, 0, 1, 0, 0);
      ld = 1'b0;
      cyc("dn.recov", 1, 2, 3, 1, 1, 0, 0);
      stop_s[1] = 1'b1;
      cyc("dn.stop", 1, 1, 0, 0, 0, 0, 0);
      stop_s[1] = 1'b0;

      // one-shot up run ending in DONE, then restart
      q1 = '{0, 1, 2, 3};
      t1 = '{1, 3, 1, 3};
      os_s[0] = 1'b1;
      start_s[0] = 1'b1;
      cyc("os.clr", 0, 2, 0, 0, 1, 0, 1);
      start_s[0] = 1'b0;
      cyc("os.run0", 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc($sformatf("os.s%0d", i), 0, q1[i], t1[i], 0, 1, 0, 0);
      cyc("os.done0", 0, 0, 0, 1, 0, 1, 0);
      for (int i = 1; i < 10; i++) cyc($sformatf("os.hold%0d", i), 0, 0, 0, 0, 0, 1, 0);
      os_s[0] = 1'b0;
      start_s[0] = 1'b1;
      cyc("os.reclr", 0, 0, 0, 0, 1, 0, 1);
      start_s[0] = 1'b0;
      cyc("os.rerun", 0, 0, 0, 0, 1, 0, 0);
      cyc("os.re0", 0, 0, 1, 0, 1, 0, 0);
      cyc("os.re1", 0, 1, 3, 0, 1, 0, 0);
      stop_s[0] = 1'b1;
      cyc("os.stop", 0, 2, 0, 0, 0, 0, 0);
      stop_s[0] = 1'b0;

      // PRESCALE=3: one step every 3 cycles, stop at q=2
      start_s[2] = 1'b1;
      cyc("ps.clr", 2, 0, 0, 0, 1, 0, 1);
      start_s[2] = 1'b0;
      cyc("ps.run0", 2, 0, 0, 0, 1, 0, 0);
      cyc("ps.c1",   2, 0, 0, 0, 1, 0, 0);
      cyc("ps.c2",   2, 0, 0, 0, 1, 0, 0);
      cyc("ps.step0", 2, 0, 1, 0, 1, 0, 0);
      cyc("ps.w1a",  2, 1, 0, 0, 1, 0, 0);
      cyc("ps.w1b",  2, 1, 0, 0, 1, 0, 0);
      cyc("ps.step1", 2, 1, 3, 0, 1, 0, 0);
      cyc("ps.w2a",  2, 2, 0, 0, 1, 0, 0);
      stop_s[2] = 1'b1;
      cyc("ps.stop", 2, 2, 0, 0, 0, 0, 0);
      stop_s[2] = 1'b0;
      cyc("ps.hold0", 2, 2, 0, 0, 0, 0, 0);
      cyc("ps.hold1", 2, 2, 0, 0, 0, 0, 0);
      start_s[2] = 1'b1; stop_s[2] = 1'b1;
      cyc("ps.both", 2, 2, 0, 0, 0, 0, 0);
      start_s[2] = 1'b0; stop_s[2] = 1'b0;
      cyc("ps.idle", 2, 2, 0, 0, 0, 0, 0);

      // synchronous clear in the middle of a run at q=3
      start_s[0] = 1'b1;
      cyc("mr.clr", 0, 2, 0, 0, 1, 0, 1);
      start_s[0] = 1'b0;
      cyc("mr.run0", 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc($sformatf("mr.s%0d", i), 0, q1[i], t1[i], 0, 1, 0, 0);
      clear = 1'b1;
      cyc("mr.rst0", 0, 0, 0, 0, 0, 0, 1);
      cyc("mr.rst1", 0, 0, 0, 0, 0, 0, 1);
      clear = 1'b0;
      cyc("mr.rel", 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
